pixel_pack: RTL

PIXEL_PACK -- requirements
Module: pixel_pack

---
 rtl/edge_pkg.sv | 12 +
 rtl/pack_out_reg.sv | 51 +++++
 rtl/pixel_pack.sv | 104 ++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared widths and lane-count type for the edge-detector pixel packing path.
package edge_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = 4;
    localparam int unsigned ACC_W   = WORD_W - PIX_W;
    localparam int unsigned BYTES_W = 3;

    typedef logic [1:0] lane_cnt_t;

endpackage

// File: rtl/pack_out_reg.sv
// Single-entry output register with valid/ready hold; reloads in the same cycle it drains.
module pack_out_reg
    import edge_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WORD_W-1:0]  load_data,
    input  logic [BYTES_W-1:0] load_bytes,
    input  logic               word_ready,
    output logic               word_valid,
    output logic [WORD_W-1:0]  word_data,
    output logic [BYTES_W-1:0] word_bytes,
    output logic               out_free
);

    logic               valid_q, valid_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic [BYTES_W-1:0] bytes_q, bytes_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            bytes_d = load_bytes;
        end else if (word_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            bytes_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
        end
    end

    assign out_free   = !valid_q || word_ready;
    assign word_valid = valid_q;
    assign word_data  = data_q;
    assign word_bytes = bytes_q;

endmodule

// File: rtl/pixel_pack.sv
// Packs 8-bit pixels LSB-first into 32-bit words; partial-word flush
// is available when PIXEL_PACK_FLUSH_EN is defined.
module pixel_pack
    import edge_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
`ifdef PIXEL_PACK_FLUSH_EN
    input  logic               flush,
`endif
    output logic               word_valid,
    output logic [WORD_W-1:0]  word_data,
    output logic [BYTES_W-1:0] word_bytes,
    input  logic               word_ready
);

    lane_cnt_t          cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               pend_q, pend_d;
    logic               flush_req;
    logic               out_free;
    logic               xfer;
    logic               load;
    logic [WORD_W-1:0]  load_data;
    logic [BYTES_W-1:0] load_bytes;
    logic [WORD_W-1:0]  merged;
    logic [2:0]         n_lanes;

`ifdef PIXEL_PACK_FLUSH_EN
    assign flush_req = flush || pend_q;
`else
    assign flush_req = 1'b0;
`endif

    assign pix_ready = rst_n && !(((cnt_q == 2'd3) && !out_free) || pend_q);
    assign xfer      = pix_valid && pix_ready;

    // Accumulator with the current pixel already dropped into its lane
    always_comb begin
        merged  = {{PIX_W{1'b0}}, acc_q};
        if (xfer)
            merged = merged | ({{(WORD_W-PIX_W){1'b0}}, pix_data} << {cnt_q, 3'b000});
        n_lanes = {1'b0, cnt_q} + {2'b00, xfer};
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        load       = 1'b0;
        load_data  = merged;
        load_bytes = n_lanes;
        if (n_lanes == 3'd4) begin
            load   = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
            pend_d = 1'b0;
        end else if (flush_req && (n_lanes != 3'd0)) begin
            // Blocked output: park the partial word and stall input until it frees
            if (out_free) begin
                load   = 1'b1;
                cnt_d  = '0;
                acc_d  = '0;
                pend_d = 1'b0;
            end else begin
                cnt_d  = n_lanes[1:0];
                acc_d  = merged[ACC_W-1:0];
                pend_d = 1'b1;
            end
        end else begin
            cnt_d = n_lanes[1:0];
            acc_d = merged[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            pend_q <= pend_d;
        end
    end

    pack_out_reg u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (load_data),
        .load_bytes (load_bytes),
        .word_ready (word_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_bytes (word_bytes),
        .out_free   (out_free)
    );

endmodule
